// File: rtl/wave_sequencer.sv
// ============================================================================
// Module   : wave_sequencer
// Purpose  : Frame-based three-channel waveform sequencer. Each channel idles
//            high, falls and rises at programmable frame counts, and the frame
//            can optionally repeat (build macro WAVE_SEQ_REPEAT_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wave_sequencer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sig1,
  output logic             sig2,
  output logic             sig3,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam int NUM_CH = 3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_frame_len;
  logic [CNT_W-1:0] r_fall [NUM_CH];
  logic [CNT_W-1:0] r_rise [NUM_CH];
  logic [NUM_CH-1:0] r_sig;

  logic w_frame_end;
  logic w_last_frame;
  logic w_run_stay;

`ifdef WAVE_SEQ_REPEAT_EN
  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] r_rep_left;
  assign w_last_frame = (r_rep_left == '0);
`else
  assign w_last_frame = 1'b1;
`endif

  assign w_frame_end = (r_frame_cnt == r_frame_len);
  assign w_run_stay  = (r_state == c_RUN) && (w_state_next == c_RUN);

  // Abort is checked first everywhere so it beats both start and frame end.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: if (start && !abort) w_state_next = c_RUN;
      c_RUN: begin
        if (abort)                            w_state_next = c_IDLE;
        else if (w_frame_end && w_last_frame) w_state_next = c_DONE;
      end
      c_DONE:  w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_next;
  end

  // Counter runs only while RUN continues; every exit and every wrap lands on 0.
  always_ff @(posedge clk) begin
    if (rst)                            r_frame_cnt <= '0;
    else if (w_run_stay && !w_frame_end) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    else                                r_frame_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_len <= CNT_W'(7);
      r_fall[0]   <= CNT_W'(3);
      r_rise[0]   <= CNT_W'(4);
      r_fall[1]   <= CNT_W'(3);
      r_rise[1]   <= CNT_W'(5);
      r_fall[2]   <= CNT_W'(2);
      r_rise[2]   <= CNT_W'(5);
`ifdef WAVE_SEQ_REPEAT_EN
      r_rep_cnt   <= '0;
`endif
    end else if (cfg_we && (r_state == c_IDLE)) begin
      case (cfg_addr)
        3'd0: r_frame_len <= cfg_wdata;
        3'd1: r_fall[0]   <= cfg_wdata;
        3'd2: r_rise[0]   <= cfg_wdata;
        3'd3: r_fall[1]   <= cfg_wdata;
        3'd4: r_rise[1]   <= cfg_wdata;
        3'd5: r_fall[2]   <= cfg_wdata;
        3'd6: r_rise[2]   <= cfg_wdata;
`ifdef WAVE_SEQ_REPEAT_EN
        3'd7: r_rep_cnt   <= cfg_wdata;
`endif
        default: ;
      endcase
    end
  end

`ifdef WAVE_SEQ_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_rep_left <= '0;
    else if ((r_state == c_IDLE) && (w_state_next == c_RUN))
      r_rep_left <= r_rep_cnt;
    else if ((r_state == c_RUN) && !abort && w_frame_end && !w_last_frame)
      r_rep_left <= r_rep_left - CNT_W'(1);
  end
`endif

  // frame_cnt never exceeds frame_len in RUN, so an edge value beyond
  // frame_len can never match and is ignored for free. Rise is tested first.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_CH; n++) begin
      if (rst || !w_run_stay)            r_sig[n] <= 1'b1;
      else if (r_frame_cnt == r_rise[n]) r_sig[n] <= 1'b1;
      else if (r_frame_cnt == r_fall[n]) r_sig[n] <= 1'b0;
    end
  end

  assign busy      = (r_state == c_RUN);
  assign done      = (r_state == c_DONE);
  assign sig1      = r_sig[0];
  assign sig2      = r_sig[1];
  assign sig3      = r_sig[2];
  assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wave_sequencer.sv
// ============================================================================
// Module   : tb_wave_sequencer
// Purpose  : Randomized self-checking bench for wave_sequencer against a
//            frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wave_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, cfg_we, start, abort;
  logic [2:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic             busy, done, sig1, sig2, sig3;
  logic [CNT_W-1:0] frame_cnt;

  wave_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .abort(abort), .busy(busy),
    .done(done), .sig1(sig1), .sig2(sig2), .sig3(sig3), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_cfg [8];
  int busy_n, done_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    m_cfg = '{7, 3, 4, 3, 5, 2, 5, 0};
  endtask

  // Caller guarantees the DUT is idle, so the model takes the write.
  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = addr[2:0]; cfg_wdata = data[CNT_W-1:0];
    tick();
    cfg_we = 1'b0;
`ifdef WAVE_SEQ_REPEAT_EN
    m_cfg[addr] = data;
`else
    if (addr != 7) m_cfg[addr] = data;
`endif
  endtask

  // abort_at/rst_at: cycle index within the run (-1 none, -2 random abort).
  // junk: 0 none, 1 random dropped writes / starts, 2 frame_len=2 write at t=1.
  task automatic run_seq(input int abort_at, input int rst_at, input int junk);
    int frames, flen, total, c, ab;
    bit lev [3];
    frames = 1;
`ifdef WAVE_SEQ_REPEAT_EN
    frames = m_cfg[7] + 1;
`endif
    flen  = m_cfg[0] + 1;
    total = frames * flen;
    ab    = (abort_at == -2) ? int'($urandom_range(0, total - 1)) : abort_at;
    lev   = '{1, 1, 1};
    busy_n = 0; done_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < total; t++) begin
      c = t % flen;
      if (busy) busy_n++;
      if (done) done_n++;
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("cnt_run", frame_cnt, c);
      check("sigs_run", {sig3, sig2, sig1}, {lev[2], lev[1], lev[0]});
      if (t == ab) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("busy_abort", busy, 0);
        check("done_abort", done, 0);
        check("sigs_abort", {sig3, sig2, sig1}, 3'b111);
        return;
      end
      if (t == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_defaults();
        check("busy_rst", busy, 0);
        check("done_rst", done, 0);
        check("cnt_rst", frame_cnt, 0);
        check("sigs_rst", {sig3, sig2, sig1}, 3'b111);
        return;
      end
      if (junk == 1) begin
        cfg_we    = ($urandom_range(0, 3) == 0);
        cfg_addr  = 3'($urandom_range(0, 7));
        cfg_wdata = CNT_W'($urandom_range(0, 15));
        start     = ($urandom_range(0, 3) == 0);
      end else if (junk == 2 && t == 1) begin
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = CNT_W'(2);
      end
      for (int n = 0; n < 3; n++) begin
        if (c == m_cfg[2 + 2*n])      lev[n] = 1;
        else if (c == m_cfg[1 + 2*n]) lev[n] = 0;
      end
      tick();
      cfg_we = 1'b0; start = 1'b0;
    end
    if (done) done_n++;
    check("busy_done", busy, 0);
    check("done_pulse", done, 1);
    check("cnt_done", frame_cnt, 0);
    check("sigs_done", {sig3, sig2, sig1}, 3'b111);
    tick();
    if (done) done_n++;
    check("done_clear", done, 0);
    check("busy_idle", busy, 0);
    check("sigs_idle", {sig3, sig2, sig1}, 3'b111);
  endtask

  initial begin
    int exp_rep;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; abort = 1'b0;
    set_defaults();
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cnt", frame_cnt, 0);
    check("reset_sigs", {sig3, sig2, sig1}, 3'b111);

    run_seq(-1, -1, 0);
    check("dflt_busy_cycles", busy_n, 8);
    check("dflt_done_count", done_n, 1);

    cfg_write(1, 5); cfg_write(2, 5);
    run_seq(-1, -1, 0);
    check("eq_edge_busy_cycles", busy_n, 8);

    run_seq(4, -1, 0);
    check("abort_busy_cycles", busy_n, 5);
    check("abort_done_count", done_n, 0);
    run_seq(-1, -1, 0);
    check("restart_busy_cycles", busy_n, 8);

    run_seq(-1, -1, 2);
    check("run_cfg_drop_cycles", busy_n, 8);

    run_seq(-1, 3, 0);
    check("rst_done_count", done_n, 0);
    run_seq(-1, -1, 0);
    check("post_rst_busy_cycles", busy_n, 8);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);

    run_seq(7, -1, 0);
    check("abort_end_done_count", done_n, 0);

    cfg_write(7, 2);
`ifdef WAVE_SEQ_REPEAT_EN
    exp_rep = 24;
`else
    exp_rep = 8;
`endif
    run_seq(-1, -1, 0);
    check("repeat_busy_cycles", busy_n, exp_rep);
    check("repeat_done_count", done_n, 1);

    cfg_write(0, 0);
    run_seq(-1, -1, 0);
    check("len0_done_count", done_n, 1);

    for (int i = 0; i < 30; i++) begin
      cfg_write(0, $urandom_range(0, 15));
      for (int a = 1; a < 7; a++) cfg_write(a, $urandom_range(0, 15));
      cfg_write(7, $urandom_range(0, 2));
      run_seq(($urandom_range(0, 3) == 0) ? -2 : -1, -1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
